// File: rtl/rc5_sched_if.sv
// Requester-side bus of rc5_sched: two request lanes packed side by side,
// one shared response channel with a per-requester valid strobe.
interface rc5_sched_if;
    logic [1:0]   req_valid;
    logic [1:0]   req_ready;
    logic [255:0] req_key;
    logic [9:0]   req_rounds;
    logic [1:0]   req_decrypt;
    logic [63:0]  req_data;
    logic [1:0]   rsp_valid;
    logic [31:0]  rsp_data;
    logic         rsp_err;

    modport master (
        output req_valid, req_key, req_rounds, req_decrypt, req_data,
        input  req_ready, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  req_valid, req_key, req_rounds, req_decrypt, req_data,
        output req_ready, rsp_valid, rsp_data, rsp_err
    );
endinterface

// File: rtl/rc5_sched.sv
// Round-robin scheduler sharing one rc5 core between two requesters, with a
// key/rounds cache that skips re-expansion and a watchdog on every core wait.
module rc5_sched #(
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic         clk,
    input  logic         rst,
    rc5_sched_if.slave   req,
    output logic [127:0] core_key,
    output logic [4:0]   core_rounds,
    output logic         core_load_key,
    input  logic         core_key_ready,
    output logic         core_start_enc,
    output logic         core_start_dec,
    output logic [31:0]  core_d_in,
    input  logic [31:0]  core_d_out,
    input  logic         core_done
);
    localparam logic [9:0] WD_LIMIT = 10'(TIMEOUT);

    typedef enum logic [2:0] {
        IDLE, LOAD, GAP, WAIT_KEY, START, WAIT_DONE, RESP
    } state_t;

    state_t       state;
    logic         ptr;
    logic         gnt_q;
    logic         dec_q;
    logic         cache_valid;
    logic [127:0] cache_key;
    logic [4:0]   cache_rounds;
    logic [9:0]   wd;

    logic         gnt;
    logic         accept;
    logic         hit;
    logic         sel_dec;
    logic [127:0] sel_key;
    logic [4:0]   sel_rounds;
    logic [31:0]  sel_data;

    // Pointer's requester wins if valid, otherwise the other lane is offered.
    always_comb begin
        gnt        = req.req_valid[ptr] ? ptr : ~ptr;
        sel_key    = gnt ? req.req_key[255:128] : req.req_key[127:0];
        sel_rounds = gnt ? req.req_rounds[9:5]  : req.req_rounds[4:0];
        sel_data   = gnt ? req.req_data[63:32]  : req.req_data[31:0];
        sel_dec    = req.req_decrypt[gnt];
        accept     = (state == IDLE) && req.req_valid[gnt];
        hit        = cache_valid && (sel_key == cache_key) && (sel_rounds == cache_rounds);
    end

    assign req.req_ready = accept ? (gnt ? 2'b10 : 2'b01) : 2'b00;

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            ptr            <= 1'b0;
            gnt_q          <= 1'b0;
            dec_q          <= 1'b0;
            cache_valid    <= 1'b0;
            cache_key      <= '0;
            cache_rounds   <= '0;
            wd             <= '0;
            core_key       <= '0;
            core_rounds    <= '0;
            core_d_in      <= '0;
            core_load_key  <= 1'b0;
            core_start_enc <= 1'b0;
            core_start_dec <= 1'b0;
            req.rsp_valid  <= '0;
            req.rsp_data   <= '0;
            req.rsp_err    <= 1'b0;
        end else begin
            core_load_key  <= 1'b0;
            core_start_enc <= 1'b0;
            core_start_dec <= 1'b0;
            req.rsp_valid  <= '0;
            req.rsp_err    <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        gnt_q       <= gnt;
                        ptr         <= ~gnt;
                        dec_q       <= sel_dec;
                        core_key    <= sel_key;
                        core_rounds <= sel_rounds;
                        core_d_in   <= sel_data;
                        if (hit) begin
                            state          <= START;
                            core_start_enc <= ~sel_dec;
                            core_start_dec <= sel_dec;
                        end else begin
                            state         <= LOAD;
                            core_load_key <= 1'b1;
                        end
                    end
                end
                LOAD: state <= GAP;
                GAP: begin
                    state <= WAIT_KEY;
                    wd    <= '0;
                end
                WAIT_KEY: begin
                    if (core_key_ready) begin
                        state          <= START;
                        cache_valid    <= 1'b1;
                        cache_key      <= core_key;
                        cache_rounds   <= core_rounds;
                        core_start_enc <= ~dec_q;
                        core_start_dec <= dec_q;
                    end else if (wd == WD_LIMIT) begin
                        state         <= RESP;
                        cache_valid   <= 1'b0;
                        req.rsp_valid <= gnt_q ? 2'b10 : 2'b01;
                        req.rsp_data  <= '0;
                        req.rsp_err   <= 1'b1;
                    end else begin
                        wd <= wd + 10'd1;
                    end
                end
                START: begin
                    state <= WAIT_DONE;
                    wd    <= '0;
                end
                WAIT_DONE: begin
                    // A done coinciding with the limit still counts as success.
                    if (core_done) begin
                        state         <= RESP;
                        req.rsp_valid <= gnt_q ? 2'b10 : 2'b01;
                        req.rsp_data  <= core_d_out;
                    end else if (wd == WD_LIMIT) begin
                        state         <= RESP;
                        cache_valid   <= 1'b0;
                        req.rsp_valid <= gnt_q ? 2'b10 : 2'b01;
                        req.rsp_data  <= '0;
                        req.rsp_err   <= 1'b1;
                    end else begin
                        wd <= wd + 10'd1;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rc5_sched.sv
// Self-checking bench for rc5_sched: behavioural rc5 core, scoreboard of
// expected responses, vector table plus contention/timeout/reset sequences.
module tb_rc5_sched;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rc5_sched_if bus();

    logic [127:0] core_key;
    logic [4:0]   core_rounds;
    logic         core_load_key;
    logic         core_key_ready = 1'b0;
    logic         core_start_enc;
    logic         core_start_dec;
    logic [31:0]  core_d_in;
    logic [31:0]  core_d_out = '0;
    logic         core_done = 1'b0;

    rc5_sched #(.TIMEOUT(1023)) dut (
        .clk(clk), .rst(rst), .req(bus),
        .core_key(core_key), .core_rounds(core_rounds),
        .core_load_key(core_load_key), .core_key_ready(core_key_ready),
        .core_start_enc(core_start_enc), .core_start_dec(core_start_dec),
        .core_d_in(core_d_in), .core_d_out(core_d_out), .core_done(core_done)
    );

    int total = 0;
    int bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Stand-in for the cipher: any cheap function of key, rounds, direction and data.
    function automatic logic [31:0] model(input logic [127:0] key, input logic [4:0] rounds,
                                          input logic dec, input logic [31:0] d);
        model = dec ? ((d ^ key[63:32]) - {27'd0, rounds}) : ((d ^ key[31:0]) + {27'd0, rounds});
    endfunction

    // Core model knobs, changed only between transactions.
    int klat = 3;
    int dlat = 2;
    bit glitch = 1'b0;
    bit spur = 1'b0;
    bit never_done = 1'b0;
    int kc = 0;
    int dc = 0;
    logic [31:0] pend = '0;

    always @(posedge clk) begin
        core_done <= 1'b0;
        if (core_load_key) begin
            core_key_ready <= glitch;
            kc <= 1;
            if (spur) begin
                core_done  <= 1'b1;
                core_d_out <= 32'hDEAD0000;
            end
        end else if (kc != 0) begin
            if (kc == klat) begin
                core_key_ready <= 1'b1;
                kc <= 0;
            end else begin
                core_key_ready <= 1'b0;
                kc <= kc + 1;
            end
        end
        if (core_start_enc || core_start_dec) begin
            if (!never_done) begin
                if (dlat <= 1) begin
                    core_done  <= 1'b1;
                    core_d_out <= model(core_key, core_rounds, core_start_dec, core_d_in);
                end else begin
                    dc   <= dlat - 1;
                    pend <= model(core_key, core_rounds, core_start_dec, core_d_in);
                end
            end
        end else if (dc != 0) begin
            if (dc == 1) begin
                core_done  <= 1'b1;
                core_d_out <= pend;
            end
            dc <= dc - 1;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [1:0]  v;
        logic [31:0] d;
        logic        e;
    } exp_t;

    exp_t sb[$];
    logic [1:0] rsp_log[$];
    int acc_cnt = 0, rsp_cnt = 0, load_cnt = 0, start_cnt = 0;
    int acc_cyc = 0, load_cyc = 0, start_cyc = 0, kr_cyc = 0, done_cyc = 0, rsp_cyc = 0;
    logic [4:0] load_rounds = '0;
    logic start_dec_seen = 1'b0;

    // Monitor: samples on the falling edge, pushes expectations on accept.
    initial begin
        logic g;
        logic mptr;
        logic kr_prev;
        exp_t e;
        logic [127:0] k;
        logic [4:0] r;
        logic [31:0] d;
        mptr = 1'b0;
        kr_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                sb.delete();
                mptr = 1'b0;
            end else begin
                if ((bus.req_valid & bus.req_ready) != 2'b00) begin
                    g = bus.req_valid[mptr] ? mptr : ~mptr;
                    check("grant", 64'(bus.req_ready), g ? 64'd2 : 64'd1);
                    k = g ? bus.req_key[255:128] : bus.req_key[127:0];
                    r = g ? bus.req_rounds[9:5] : bus.req_rounds[4:0];
                    d = g ? bus.req_data[63:32] : bus.req_data[31:0];
                    e.v = g ? 2'b10 : 2'b01;
                    e.e = never_done;
                    e.d = never_done ? 32'd0 : model(k, r, bus.req_decrypt[g], d);
                    sb.push_back(e);
                    mptr = ~g;
                    acc_cnt++;
                    acc_cyc = cyc;
                end
                if (core_load_key) begin
                    load_cnt++;
                    load_cyc = cyc;
                    load_rounds = core_rounds;
                end
                if (core_start_enc || core_start_dec) begin
                    start_cnt++;
                    start_cyc = cyc;
                    start_dec_seen = core_start_dec;
                end
                if (core_key_ready && !kr_prev) kr_cyc = cyc;
                if (core_done) done_cyc = cyc;
                if (bus.rsp_valid != 2'b00) begin
                    rsp_cnt++;
                    rsp_cyc = cyc;
                    rsp_log.push_back(bus.rsp_valid);
                    if (sb.size() == 0)
                        check("rsp_unexpected", {29'd0, bus.rsp_valid, bus.rsp_data, bus.rsp_err}, 64'd0);
                    else begin
                        e = sb.pop_front();
                        check("rsp", {29'd0, bus.rsp_valid, bus.rsp_data, bus.rsp_err}, {29'd0, e});
                    end
                end
            end
            kr_prev = core_key_ready;
        end
    end

    task automatic drive_lane(input int id, input logic [127:0] key, input logic [4:0] rounds,
                              input logic dec, input logic [31:0] data);
        if (id == 0) begin
            bus.req_key[127:0] = key;
            bus.req_rounds[4:0] = rounds;
            bus.req_decrypt[0] = dec;
            bus.req_data[31:0] = data;
        end else begin
            bus.req_key[255:128] = key;
            bus.req_rounds[9:5] = rounds;
            bus.req_decrypt[1] = dec;
            bus.req_data[63:32] = data;
        end
    endtask

    task automatic issue(input int id, input logic [127:0] key, input logic [4:0] rounds,
                         input logic dec, input logic [31:0] data);
        int c0;
        c0 = acc_cnt;
        @(posedge clk);
        #1;
        drive_lane(id, key, rounds, dec, data);
        bus.req_valid[id] = 1'b1;
        for (int i = 0; i < 50 && acc_cnt == c0; i++) @(posedge clk);
        #1;
        bus.req_valid = 2'b00;
        check("accept", 64'(acc_cnt), 64'(c0 + 1));
    endtask

    task automatic wait_rsp(input int target, input int limit);
        for (int i = 0; i < limit && rsp_cnt < target; i++) @(posedge clk);
        #1;
        check("rsp_count", 64'(rsp_cnt), 64'(target));
    endtask

    task automatic check_idle_outputs(input string name);
        check({name, "_ctl"}, 64'({bus.req_ready, bus.rsp_valid, bus.rsp_err,
                                    core_load_key, core_start_enc, core_start_dec}), 64'd0);
        check({name, "_data"}, {bus.rsp_data, core_d_in}, 64'd0);
        check({name, "_key"}, 64'(|{core_key, core_rounds}), 64'd0);
    endtask

    typedef struct {
        int          id;
        logic [127:0] key;
        logic [4:0]  rounds;
        logic        dec;
        logic [31:0] data;
        bit          miss;
        int          kl;
        int          dl;
        bit          gl;
        bit          sp;
    } vec_t;

    localparam logic [127:0] K1 = 128'h2B7E151628AED2A6ABF7158809CF4F3C;
    localparam logic [127:0] K2 = 128'h000102030405060708090A0B0C0D0E0F;

    initial begin
        vec_t vt[6];
        int l0, r0, c0, s0;
        vt[0] = '{0, K1, 5'd31, 1'b0, 32'hD87FAB42, 1'b1, 3, 4, 1'b0, 1'b0};
        vt[1] = '{0, K1, 5'd31, 1'b0, 32'h00000000, 1'b0, 3, 1, 1'b0, 1'b0};
        vt[2] = '{1, K1, 5'd12, 1'b1, 32'h12345678, 1'b1, 2, 3, 1'b1, 1'b0};
        vt[3] = '{1, K1, 5'd12, 1'b1, 32'hCAFEBABE, 1'b0, 2, 2, 1'b0, 1'b0};
        vt[4] = '{0, K2, 5'd12, 1'b0, 32'h0BADF00D, 1'b1, 5, 2, 1'b0, 1'b1};
        vt[5] = '{1, K2, 5'd12, 1'b0, 32'hFFFFFFFF, 1'b0, 3, 6, 1'b0, 1'b0};

        bus.req_valid = '0;
        bus.req_key = '0;
        bus.req_rounds = '0;
        bus.req_decrypt = '0;
        bus.req_data = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            klat = vt[i].kl;
            dlat = vt[i].dl;
            glitch = vt[i].gl;
            spur = vt[i].sp;
            l0 = load_cnt;
            r0 = rsp_cnt;
            issue(vt[i].id, vt[i].key, vt[i].rounds, vt[i].dec, vt[i].data);
            wait_rsp(r0 + 1, 100);
            check($sformatf("v%0d_loads", i), 64'(load_cnt - l0), vt[i].miss ? 64'd1 : 64'd0);
            if (vt[i].miss) begin
                check($sformatf("v%0d_load_at", i), 64'(load_cyc), 64'(acc_cyc + 1));
                check($sformatf("v%0d_load_rounds", i), 64'(load_rounds), 64'(vt[i].rounds));
                check($sformatf("v%0d_start_after_kr", i), 64'(start_cyc), 64'(kr_cyc + 1));
            end else begin
                check($sformatf("v%0d_start_at", i), 64'(start_cyc), 64'(acc_cyc + 1));
                check($sformatf("v%0d_latency", i), 64'(rsp_cyc - acc_cyc), 64'(2 + vt[i].dl));
            end
            check($sformatf("v%0d_rsp_after_done", i), 64'(rsp_cyc), 64'(done_cyc + 1));
            check($sformatf("v%0d_dir", i), 64'(start_dec_seen), 64'(vt[i].dec));
        end
        glitch = 1'b0;
        spur = 1'b0;

        // Contention: both lanes held valid, pointer currently at req0.
        dlat = 2;
        r0 = rsp_cnt;
        c0 = acc_cnt;
        rsp_log.delete();
        @(posedge clk);
        #1;
        drive_lane(0, K2, 5'd12, 1'b0, 32'h11111111);
        drive_lane(1, K2, 5'd12, 1'b0, 32'h22222222);
        bus.req_valid = 2'b11;
        for (int i = 0; i < 200 && acc_cnt < c0 + 3; i++) @(posedge clk);
        #1;
        bus.req_valid = 2'b00;
        wait_rsp(r0 + 3, 100);
        check("cont_order", 64'({rsp_log[0], rsp_log[1], rsp_log[2]}), 64'({2'b01, 2'b10, 2'b01}));

        // Watchdog in WAIT_DONE, then the cache must be invalid.
        never_done = 1'b1;
        r0 = rsp_cnt;
        issue(0, K2, 5'd12, 1'b0, 32'h55AA55AA);
        wait_rsp(r0 + 1, 1100);
        check("to_latency", 64'(rsp_cyc), 64'(start_cyc + 1025));
        never_done = 1'b0;
        klat = 3;
        l0 = load_cnt;
        r0 = rsp_cnt;
        issue(0, K2, 5'd12, 1'b0, 32'h01020304);
        wait_rsp(r0 + 1, 100);
        check("to_reload", 64'(load_cnt - l0), 64'd1);

        // Reset while waiting for a slow done.
        dlat = 20;
        s0 = start_cnt;
        r0 = rsp_cnt;
        issue(1, K2, 5'd12, 1'b1, 32'h0F0F0F0F);
        for (int i = 0; i < 20 && start_cnt == s0; i++) @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_idle_outputs("midrst");
        rst = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        check("midrst_no_rsp", 64'(rsp_cnt), 64'(r0));
        dlat = 2;
        l0 = load_cnt;
        r0 = rsp_cnt;
        issue(1, K2, 5'd12, 1'b1, 32'hA5A5A5A5);
        wait_rsp(r0 + 1, 100);
        check("midrst_reload", 64'(load_cnt - l0), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/rc5_sched.md
# rc5_sched

Request scheduler that shares one `rc5` encrypt/decrypt core between two requesters. It arbitrates round-robin and sequences the core's key-load and start/done handshakes. It caches the last loaded key and round count so that back-to-back operations with an unchanged key skip expansion. It also guards every operation with a done-watchdog. It sits between the two requesting masters and the `rc5` core ports (`load_key`, `key_ready`, `start_encrypt`, `start_decrypt`, `d_in`, `d_out`, `done`).

## Interface
Parameters:
- `TIMEOUT`, default 1023: cycles in WAIT_KEY or WAIT_DONE before abort; 10-bit counter.

Ports:
- `clk`  in  1  clock; all logic on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  2  request strobe, bit i = requester i.
- `req_ready`  out  2  accept; a request transfers when valid & ready are both high.
- `req_key`  in  256  key per requester; [128i+127:128i].
- `req_rounds`  in  10  round count per requester; [5i+4:5i].
- `req_decrypt`  in  2  1 = decrypt, 0 = encrypt.
- `req_data`  in  64  32-bit block per requester; [32i+31:32i].
- `rsp_valid`  out  2  one-cycle response pulse to requester i; no backpressure.
- `rsp_data`  out  32  result, valid with `rsp_valid`.
- `rsp_err`  out  1  1 = watchdog abort; `rsp_data` = 0.
- `core_key`  out  128  to core `key`.
- `core_rounds`  out  5  to core `num_rounds`.
- `core_load_key`  out  1  one-cycle pulse.
- `core_key_ready`  in  1  from core.
- `core_start_enc`, `core_start_dec`  out  1 each  one-cycle pulses.
- `core_d_in`  out  32  to core.
- `core_d_out`  in  32  from core.
- `core_done`  in  1  from core.

## Operation
- Reset values of all outputs are 0. The internal state after reset is: state = IDLE, priority pointer = 0, cache_valid = 0, watchdog = 0.
- Core contract: after sampling `load_key`, the core drops `key_ready` by the following cycle and raises it when expansion completes. `done` is a one-cycle pulse carrying `d_out`.
- IDLE: the grant goes to the pointer's requester if it is valid, otherwise to the other requester. `req_ready` is combinational: high only in IDLE and only for the granted bit. On transfer, the block latches key, rounds, decrypt and data, and the pointer is set to the non-granted requester.
- Hit test on accept: a hit means cache_valid and latched key == cached key and rounds == cached rounds. Hit goes to START; miss goes to LOAD.
- LOAD: pulse `core_load_key` and drive `core_key`/`core_rounds`. Go to GAP.
- GAP: one dead cycle in which `key_ready` is ignored. Go to WAIT_KEY.
- WAIT_KEY: when `key_ready` = 1, set cache = latched key/rounds, set cache_valid = 1, and go to START.
- START: pulse `core_start_dec` or `core_start_enc` with `core_d_in` driven. Go to WAIT_DONE.
- WAIT_DONE: on `core_done`, capture `core_d_out` and go to RESP.
- RESP: `rsp_valid[grant]` = 1, `rsp_err` = 0. Go to IDLE.
- Watchdog: clears on entry to WAIT_KEY and on entry to WAIT_DONE, and increments in those states. On reaching `TIMEOUT`, the block clears cache_valid, issues a RESP with `rsp_err` = 1 and `rsp_data` = 0, then returns to IDLE.
- `core_key`, `core_rounds` and `core_d_in` hold their latched values from accept until the next accept.
- `rst` asserted in any state takes effect at the next edge: the state is forced to IDLE, cache_valid is cleared, and no response is issued for the in-flight request.

## Timing
- Accept at cycle N.
- Hit case:
  - The start pulse is at N+1.
  - If `done` is sampled at cycle M, `rsp_valid` is high at M+1.
  - The minimum hit latency from accept to response is 3 cycles, when done arrives at N+2.
- Miss case:
  - `load_key` at N+1, gap at N+2, `key_ready` sampled from N+3.
  - If `key_ready` is first high at K, the start pulse is at K+1.
- The earliest next accept is the cycle after RESP. Throughput is at most one request per (latency + 1) cycles.
- Simultaneous `req_valid` = 2'b11 from IDLE: the pointer's requester wins; the other requester wins the next accept.
- A `done` that arrives in any state other than WAIT_DONE is ignored.
- A `key_ready` that is high during GAP is ignored.

## Test plan
- Miss, encrypt: req0 with key 2B7E151628AED2A6ABF7158809CF4F3C, rounds 31, data D87FAB42. Expect one `load_key` pulse, a start pulse one cycle after `key_ready` rises, and `rsp_valid` = 2'b01 with `rsp_data` equal to the core `d_out`, `rsp_err` = 0.
- Hit: repeat with the same key and rounds and data 00000000. Expect no `load_key`, the start pulse at N+1, and a response 1 cycle after `done`.
- Rounds change: same key, rounds 12, decrypt. Expect a reload with `core_rounds` = 12 and the `core_start_dec` pulse.
- Contention: both `req_valid` held high with pointer = 0. Expect the grant order req0, req1, req0, and `rsp_valid` alternating 01, 10, 01.
- Timeout: the core never raises `done`. Expect `rsp_err` = 1 and `rsp_data` = 0 at WAIT_DONE entry + 1023 + 1. The next request with the same key must reload (`load_key` pulse).
- Reset mid-operation: assert `rst` in WAIT_DONE. Expect all outputs 0 the next cycle and no `rsp_valid`. A same-key request after reset must reload.
